// File: rtl/drra_apb_pkg.sv
// Shared definitions for the DRRA APB program loader: register offsets, error codes, FSM states.
// No logic; latency and backpressure are properties of the modules importing this package.
package drra_apb_pkg;

    localparam logic [31:0] CTRL_OFF_CFG  = 32'h0;
    localparam logic [31:0] CTRL_OFF_CALL = 32'h4;
    localparam logic [31:0] CTRL_OFF_RET  = 32'h8;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_PSLVERR = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_BAD_CMD = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CTRL,
        S_LOAD,
        S_CALL,
        S_POLL,
        S_DONE,
        S_ERR
    } loader_state_t;

    typedef enum logic [1:0] {
        M_IDLE,
        M_SETUP,
        M_ACCESS
    } apb_phase_t;

endpackage

// File: rtl/apb_master_port.sv
// Single-transfer APB master: req is taken only when idle, ack pulses combinationally on PREADY.
// Latency: setup + >=1 access cycle; backpressure: PREADY low stretches the access phase.
module apb_master_port
    import drra_apb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          PSEL,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-1:0] PADDR,
    output logic [DW-1:0] PWDATA,
    input  logic [DW-1:0] PRDATA,
    input  logic          PREADY,
    input  logic          PSLVERR
);

    apb_phase_t phase, phase_nxt;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= M_IDLE;
        end else begin
            phase <= phase_nxt;
        end
    end

    always_comb begin
        phase_nxt = phase;
        unique case (phase)
            M_IDLE:   if (req) phase_nxt = M_SETUP;
            M_SETUP:  phase_nxt = M_ACCESS;
            M_ACCESS: if (PREADY) phase_nxt = M_IDLE;
            default:  phase_nxt = M_IDLE;
        endcase
    end

    // Transfer attributes are frozen at request time so they stay stable through wait states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (phase == M_IDLE && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    assign PSEL    = (phase != M_IDLE);
    assign PENABLE = (phase == M_ACCESS);
    assign PWRITE  = we_q;
    assign PADDR   = addr_q;
    assign PWDATA  = wdata_q;

    assign ack   = (phase == M_ACCESS) && PREADY;
    assign err   = ack && PSLVERR;
    assign rdata = PRDATA;

endmodule

// File: rtl/apb_program_loader.sv
// Loads a program into a DRRA row over APB, calls it, and polls ret status until done or error.
// Latency: one APB transfer per step, 1 idle cycle between; backpressure: instr_ready only when bus is free.
module apb_program_loader
    import drra_apb_pkg::*;
#(
    parameter int              APB_AW           = 32,
    parameter int              APB_DW           = 32,
    parameter int              ROWS             = 1,
    parameter int              COLS             = 2,
    parameter logic [APB_AW-1:0] INSTR_BASE_ADDR = 'h0000,
    parameter int              INSTR_SIZE_BYTES = 256,
    parameter logic [APB_AW-1:0] CTRL_BASE_ADDR  = 'h0C00,
    parameter int              POLL_TIMEOUT     = 1024,
    localparam int             MAX_WORDS        = INSTR_SIZE_BYTES / ROWS / 4,
    localparam int             NW_W             = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       row,
    input  logic [15:0]       col,
    input  logic [NW_W-1:0]   num_words,
    input  logic              instr_valid,
    input  logic [APB_DW-1:0] instr_data,
    output logic              instr_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [APB_AW-1:0] PADDR,
    output logic [APB_DW-1:0] PWDATA,
    input  logic [APB_DW-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int PC_W   = $clog2(POLL_TIMEOUT + 1);
    localparam int RSEL_W = $clog2(APB_DW);

    loader_state_t state, state_nxt;
    err_code_t     err_q, code_nxt;

    logic              in_flight;
    logic              bad_cmd_q;
    logic [NW_W-1:0]   idx;
    logic [NW_W-1:0]   cmd_words;
    logic [PC_W-1:0]   poll_cnt;
    logic [15:0]       cmd_row;
    logic [15:0]       cmd_col;

    logic              cmd_ok;
    logic              cmd_accept;
    logic              cmd_reject;
    logic              code_we;
    logic              word_accept;
    logic              poll_retry;

    logic              m_req;
    logic              m_we;
    logic              m_ack;
    logic              m_err;
    logic [APB_AW-1:0] m_addr;
    logic [APB_DW-1:0] m_wdata;
    logic [APB_DW-1:0] m_rdata;

    // Range check up front keeps every later address computation inside the instruction region.
    assign cmd_ok = (row < 16'(ROWS)) && (col < 16'(COLS)) && (num_words <= NW_W'(MAX_WORDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        m_req       = 1'b0;
        m_we        = 1'b1;
        m_addr      = '0;
        m_wdata     = '0;
        instr_ready = 1'b0;
        word_accept = 1'b0;
        poll_retry  = 1'b0;
        cmd_accept  = 1'b0;
        cmd_reject  = 1'b0;
        code_we     = 1'b0;
        code_nxt    = ERR_NONE;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    code_we = 1'b1;
                    if (cmd_ok) begin
                        cmd_accept = 1'b1;
                        state_nxt  = S_CTRL;
                    end else begin
                        cmd_reject = 1'b1;
                        code_nxt   = ERR_BAD_CMD;
                    end
                end
            end
            S_CTRL: begin
                m_req   = !in_flight;
                m_addr  = CTRL_BASE_ADDR + APB_AW'(CTRL_OFF_CFG);
                m_wdata = APB_DW'({cmd_col, cmd_row});
                if (m_ack) state_nxt = (cmd_words != '0) ? S_LOAD : S_CALL;
            end
            S_LOAD: begin
                instr_ready = !in_flight && (idx < cmd_words);
                word_accept = instr_valid && instr_ready;
                m_req       = word_accept;
                m_addr      = INSTR_BASE_ADDR + (APB_AW'(idx) << 2);
                m_wdata     = instr_data;
                // idx already advanced on acceptance, so equality marks the last word's completion.
                if (m_ack && idx == cmd_words) state_nxt = S_CALL;
            end
            S_CALL: begin
                m_req   = !in_flight;
                m_addr  = CTRL_BASE_ADDR + APB_AW'(CTRL_OFF_CALL);
                m_wdata = APB_DW'(1);
                if (m_ack) state_nxt = S_POLL;
            end
            S_POLL: begin
                m_req  = !in_flight;
                m_we   = 1'b0;
                m_addr = CTRL_BASE_ADDR + APB_AW'(CTRL_OFF_RET);
                if (m_ack) begin
                    if (m_rdata[cmd_row[RSEL_W-1:0]]) begin
                        state_nxt = S_DONE;
                    end else if (poll_cnt == PC_W'(POLL_TIMEOUT - 1)) begin
                        state_nxt = S_ERR;
                        code_we   = 1'b1;
                        code_nxt  = ERR_TIMEOUT;
                    end else begin
                        poll_retry = 1'b1;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // A slave error on any transfer wins over whatever the step above decided.
        if (m_err) begin
            state_nxt  = S_ERR;
            code_we    = 1'b1;
            code_nxt   = ERR_PSLVERR;
            poll_retry = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= 1'b0;
            bad_cmd_q <= 1'b0;
            err_q     <= ERR_NONE;
            idx       <= '0;
            cmd_words <= '0;
            poll_cnt  <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;
        end else begin
            bad_cmd_q <= cmd_reject;
            if (code_we) err_q <= code_nxt;
            if (m_req) begin
                in_flight <= 1'b1;
            end else if (m_ack) begin
                in_flight <= 1'b0;
            end
            if (cmd_accept) begin
                cmd_row   <= row;
                cmd_col   <= col;
                cmd_words <= num_words;
                idx       <= '0;
                poll_cnt  <= '0;
            end
            if (word_accept) idx <= idx + 1'b1;
            if (poll_retry) poll_cnt <= poll_cnt + 1'b1;
        end
    end

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERR) || bad_cmd_q;
    assign err_code = err_q;

    apb_master_port #(
        .AW (APB_AW),
        .DW (APB_DW)
    ) u_apb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (m_req),
        .we      (m_we),
        .addr    (m_addr),
        .wdata   (m_wdata),
        .ack     (m_ack),
        .rdata   (m_rdata),
        .err     (m_err),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

endmodule

// File: tb/tb_apb_program_loader.sv
// Scoreboard bench for apb_program_loader: directed commands, APB slave model, event monitor.
// Expected APB transfers and done/error pulses are queued by the stimulus and popped by the monitor.
module tb_apb_program_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] row;
    logic [15:0] col;
    logic [6:0]  num_words;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic        instr_ready;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb_program_loader #(
        .POLL_TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .row         (row),
        .col         (col),
        .num_words   (num_words),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_ready (instr_ready),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    // kind: 0 APB write, 1 APB read, 2 done pulse, 3 error pulse (data = err_code)
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          psel_cycles;
    logic [31:0] wbuf[8];

    // slave model knobs, written only by the stimulus process
    int          stall      = 0;
    int          poll_zeros = 0;
    logic        err_en     = 1'b0;
    logic [31:0] err_addr   = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic push_w(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = 0; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_r(input logic [31:0] a);
        exp_t e;
        e.kind = 1; e.addr = a; e.data = 32'h0;
        exp_q.push_back(e);
    endtask

    task automatic push_evt(input int k, input logic [31:0] d);
        exp_t e;
        e.kind = k; e.addr = 32'h0; e.data = d;
        exp_q.push_back(e);
    endtask

    // APB slave: responds 2 ns after each edge so it never races the stimulus process.
    initial begin
        int wait_cnt;
        int rd_cnt;
        wait_cnt = 0;
        rd_cnt   = 0;
        PREADY   = 1'b0;
        PRDATA   = 32'h0;
        PSLVERR  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                PREADY = 1'b0; PSLVERR = 1'b0; wait_cnt = 0; rd_cnt = 0;
            end else begin
                if (start) rd_cnt = 0;
                if (PSEL && PENABLE) begin
                    if (wait_cnt < stall) begin
                        PREADY = 1'b0;
                        wait_cnt++;
                    end else begin
                        PREADY  = 1'b1;
                        PSLVERR = err_en && PWRITE && (PADDR == err_addr);
                        PRDATA  = (!PWRITE && rd_cnt >= poll_zeros) ? 32'h1 : 32'h0;
                        if (!PWRITE) rd_cnt++;
                    end
                end else begin
                    PREADY = 1'b0; PSLVERR = 1'b0; wait_cnt = 0;
                end
            end
        end
    end

    // Monitor: checks every DUT-visible event against the head of the expectation queue.
    initial begin
        exp_t        e;
        logic [31:0] s_addr;
        logic [31:0] s_data;
        s_addr = 32'h0;
        s_data = 32'h0;
        psel_cycles = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (start) psel_cycles = 0;
                if (PSEL) psel_cycles++;
                if (PSEL && !PENABLE) begin
                    s_addr = PADDR;
                    s_data = PWDATA;
                end
                if (PSEL && PENABLE) begin
                    chk("paddr_stable", PADDR, s_addr);
                    chk("pwdata_stable", PWDATA, s_data);
                end
                if (PSEL && PENABLE && PREADY) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_apb", PADDR, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("apb_kind", PWRITE ? 32'd0 : 32'd1, e.kind);
                        chk("paddr", PADDR, e.addr);
                        if (PWRITE) chk("pwdata", PWDATA, e.data);
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd2, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_kind", 32'd2, e.kind);
                    end
                end
                if (error) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_error", {30'd0, err_code}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("error_kind", 32'd3, e.kind);
                        chk("err_code", {30'd0, err_code}, e.data);
                    end
                end
            end
        end
    end

    task automatic do_start(input logic [15:0] r, input logic [15:0] c, input logic [6:0] n);
        start = 1'b1; row = r; col = c; num_words = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offers wbuf[0..n-1]; after each acceptance holds valid low for gap cycles.
    task automatic feed(input int n, input int gap, output int accepted);
        int budget;
        logic took;
        accepted = 0;
        budget   = 0;
        while (accepted < n && budget < 400 && busy) begin
            instr_valid = 1'b1;
            instr_data  = wbuf[accepted];
            @(negedge clk);
            took = instr_ready;
            @(posedge clk); #1;
            budget++;
            if (took) begin
                accepted++;
                instr_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
        end
        instr_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || busy) && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: pending=%0d busy=%0b, expected 0 and 0", tag, exp_q.size(), busy);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        rst_n = 1'b0; start = 1'b0; row = 16'd0; col = 16'd0; num_words = 7'd0;
        instr_valid = 1'b0; instr_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_busy", busy, 0);
        chk("rst_done_error", {done, error}, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_instr_ready", instr_ready, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: three words, zero-wait slave, ret bit set on first poll
        wbuf[0] = 32'hA0A0_0001; wbuf[1] = 32'hB0B0_0002; wbuf[2] = 32'hC0C0_0003;
        push_w(32'hC00, 32'h0001_0000);
        push_w(32'h000, 32'hA0A0_0001);
        push_w(32'h004, 32'hB0B0_0002);
        push_w(32'h008, 32'hC0C0_0003);
        push_w(32'hC04, 32'h1);
        push_r(32'hC08);
        push_evt(2, 0);
        do_start(16'd0, 16'd1, 7'd3);
        feed(3, 0, acc);
        wait_quiet("t1");
        chk("t1_apb_cycles", psel_cycles, 12);
        chk("t1_err_code", err_code, 0);

        // 2: gapped stream, 2 wait states per access, a start while busy is ignored
        stall = 2;
        wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222; wbuf[2] = 32'h3333_3333; wbuf[3] = 32'h4444_4444;
        push_w(32'hC00, 32'h0000_0000);
        push_w(32'h000, 32'h1111_1111);
        push_w(32'h004, 32'h2222_2222);
        push_w(32'h008, 32'h3333_3333);
        push_w(32'h00C, 32'h4444_4444);
        push_w(32'hC04, 32'h1);
        push_r(32'hC08);
        push_evt(2, 0);
        do_start(16'd0, 16'd0, 7'd4);
        do_start(16'd5, 16'd0, 7'd1);
        chk("t2_busy_after_ignored_start", busy, 1);
        feed(4, 2, acc);
        chk("t2_words_taken", acc, 4);
        wait_quiet("t2");
        chk("t2_err_code", err_code, 0);
        stall = 0;

        // 3a: ret bit clear for 4 polls, then set
        poll_zeros = 4;
        wbuf[0] = 32'hDEAD_BEEF;
        push_w(32'hC00, 32'h0001_0000);
        push_w(32'h000, 32'hDEAD_BEEF);
        push_w(32'hC04, 32'h1);
        repeat (5) push_r(32'hC08);
        push_evt(2, 0);
        do_start(16'd0, 16'd1, 7'd1);
        feed(1, 0, acc);
        wait_quiet("t3a");

        // 3b: ret never set -> timeout after POLL_TIMEOUT reads
        poll_zeros = 1000;
        push_w(32'hC00, 32'h0000_0000);
        push_w(32'hC04, 32'h1);
        repeat (8) push_r(32'hC08);
        push_evt(3, 2);
        do_start(16'd0, 16'd0, 7'd0);
        wait_quiet("t3b");
        chk("t3b_err_code_held", err_code, 2);
        poll_zeros = 0;

        // 4: slave error on the second instruction write
        err_en = 1'b1; err_addr = 32'h4;
        wbuf[0] = 32'h0A0A_0A0A; wbuf[1] = 32'h0B0B_0B0B; wbuf[2] = 32'h0C0C_0C0C;
        push_w(32'hC00, 32'h0001_0000);
        push_w(32'h000, 32'h0A0A_0A0A);
        push_w(32'h004, 32'h0B0B_0B0B);
        push_evt(3, 1);
        do_start(16'd0, 16'd1, 7'd3);
        feed(3, 0, acc);
        chk("t4_words_taken", acc, 2);
        chk("t4_instr_ready", instr_ready, 0);
        wait_quiet("t4");
        chk("t4_err_code_held", err_code, 1);
        err_en = 1'b0;

        // 5: bad commands (row, word count, column), then a call-only run
        push_evt(3, 3);
        do_start(16'd1, 16'd0, 7'd2);
        @(negedge clk);
        chk("t5_row_busy", busy, 0);
        @(posedge clk); #1;
        wait_quiet("t5a");
        chk("t5_row_code", err_code, 3);
        push_evt(3, 3);
        do_start(16'd0, 16'd0, 7'd65);
        wait_quiet("t5b");
        chk("t5_words_code", err_code, 3);
        push_evt(3, 3);
        do_start(16'd0, 16'd2, 7'd1);
        wait_quiet("t5c");
        push_w(32'hC00, 32'h0001_0000);
        push_w(32'hC04, 32'h1);
        push_r(32'hC08);
        push_evt(2, 0);
        do_start(16'd0, 16'd1, 7'd0);
        wait_quiet("t5d");
        chk("t5d_err_code_cleared", err_code, 0);

        // 6: reset while an instruction write is stalled, then a clean full run
        stall = 2;
        wbuf[0] = 32'h5555_0000;
        push_w(32'hC00, 32'h0000_0000);
        do_start(16'd0, 16'd0, 7'd3);
        feed(1, 0, acc);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_psel_before_reset", PSEL, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_psel_async", PSEL, 0);
        chk("t6_penable_async", PENABLE, 0);
        chk("t6_busy_async", busy, 0);
        chk("t6_instr_ready_async", instr_ready, 0);
        chk("t6_pending_before_reset", exp_q.size(), 0);
        exp_q.delete();
        stall = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wbuf[0] = 32'hD000_000D; wbuf[1] = 32'hE000_000E; wbuf[2] = 32'hF000_000F;
        push_w(32'hC00, 32'h0000_0000);
        push_w(32'h000, 32'hD000_000D);
        push_w(32'h004, 32'hE000_000E);
        push_w(32'h008, 32'hF000_000F);
        push_w(32'hC04, 32'h1);
        push_r(32'hC08);
        push_evt(2, 0);
        do_start(16'd0, 16'd0, 7'd3);
        feed(3, 0, acc);
        wait_quiet("t6");
        chk("t6_apb_cycles", psel_cycles, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
